regfile_sb: RTL and testbench

// - Parametrised successor to the single-write RISC-V integer register file: NR read ports, NW write ports, optional hardwired x0.
// - Adds write-first bypass and a per-register pending-write scoreboard, so decode can detect RAW hazards on in-flight producers.
// - Sits between decode (read/issue) and writeback (write/clear busy).

---
 rtl/riscv_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer core constants used by the register file and its scoreboard.
package riscv_pkg;

  localparam int RV_XLEN          = 32;
  localparam int REG_DEPTH        = 32;
  localparam int REG_AW           = $clog2(REG_DEPTH);
  localparam int ZERO_REG_DEFAULT = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH,
  parameter int NW       = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NW-1:0]      we,
  input  logic [NW*AW-1:0]   waddr,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_addr,
  output logic [DEPTH-1:0]   busy,
  output logic [CW-1:0]      busy_cnt
);

  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  // A set and a clear on the same register means a newer producer issued: set wins.
  always_comb begin
    clr_vec  = '0;
    set_vec  = '0;
    busy_nxt = '0;
    cnt_nxt  = '0;
    for (int p = 0; p < NW; p++) begin
      if (we[p]) begin
        clr_vec[waddr[p*AW +: AW]] = 1'b1;
      end
    end
    if (sb_set) begin
      set_vec[sb_addr] = 1'b1;
    end
    busy_nxt = set_vec | (busy & ~clr_vec);
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-first bypass and a RAW-hazard scoreboard.
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int DEPTH    = REG_DEPTH,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     waddr,
  input  logic [NW*XLEN-1:0]   wdata,
  input  logic [NR*AW-1:0]     raddr,
  output logic [NR*XLEN-1:0]   rdata,
  output logic [NR-1:0]        rbusy,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic [CW-1:0]        busy_cnt
);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [NW-1:0]    wact;
  logic [AW-1:0]    rd_addr;
  logic [XLEN-1:0]  rd_val;
  logic             rd_hit;

  // While reset is held no write takes effect, so none may be forwarded either.
  assign wact = we & {NW{rst_n}};

  // Later ports overwrite earlier ones, giving the highest enabled port priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (we[p] && !(ZERO_REG != 0 && waddr[p*AW +: AW] == '0)) begin
          regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rdata   = '0;
    rbusy   = '0;
    rd_addr = '0;
    rd_val  = '0;
    rd_hit  = 1'b0;
    for (int r = 0; r < NR; r++) begin
      rd_addr = raddr[r*AW +: AW];
      rd_val  = regs[rd_addr];
      rd_hit  = 1'b0;
      for (int p = 0; p < NW; p++) begin
        if (wact[p] && waddr[p*AW +: AW] == rd_addr) begin
          rd_val = wdata[p*XLEN +: XLEN];
          rd_hit = 1'b1;
        end
      end
      if (ZERO_REG != 0 && rd_addr == '0) begin
        rd_val = '0;
        rd_hit = 1'b0;
      end
      rdata[r*XLEN +: XLEN] = rd_val;
      rbusy[r]              = busy[rd_addr] & ~rd_hit;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table through a scoreboard queue plus reset corner cases.
module tb_regfile_sb;

  logic         clk;
  logic         rst_n;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic [1:0]   rbusy;
  logic         sb_set;
  logic [4:0]   sb_addr;
  logic [5:0]   busy_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sbs;
    logic [4:0]  sba;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  regfile_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic s, input logic [4:0] sa,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic [5:0] ec);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.ra0 = r0; v.ra1 = r1; v.sbs = s; v.sba = sa;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    we      = v.we;
    waddr   = {v.wa1, v.wa0};
    wdata   = {v.wd1, v.wd0};
    raddr   = {v.ra1, v.ra0};
    sb_set  = v.sbs;
    sb_addr = v.sba;
    expq.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (expq.size() == 0) begin
      check($sformatf("v%0d_queue_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = expq.pop_front();
    check($sformatf("v%0d_rdata0", idx), rdata[31:0], e.e_rd0);
    check($sformatf("v%0d_rdata1", idx), rdata[63:32], e.e_rd1);
    check($sformatf("v%0d_rbusy", idx), {30'd0, rbusy}, {30'd0, e.e_rb});
    check($sformatf("v%0d_busy_cnt", idx), {26'd0, busy_cnt}, {26'd0, e.e_cnt});
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    raddr = '0;

    // Columns: we, wa0, wd0, wa1, wd1, ra0, ra1, sb_set, sb_addr | rdata0, rdata1, rbusy, busy_cnt
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd31, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,    5'd5,  5'd0,  1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd5,  5'd5,  1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0));
    vecs.push_back(mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,    5'd0,  5'd5,  1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd6,  1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b11, 5'd7, 32'h1111,     5'd7, 32'h2222, 5'd7,  5'd7,  1'b0, 5'd0, 32'h2222,     32'h2222,     2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd7,  5'd5,  1'b0, 5'd0, 32'h2222,     32'hDEADBEEF, 2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3,  5'd7,  1'b1, 5'd3, 32'h0,        32'h2222,     2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3,  5'd3,  1'b0, 5'd0, 32'h0,        32'h0,        2'b11, 6'd1));
    vecs.push_back(mk(2'b01, 5'd3, 32'h55,       5'd0, 32'h0,    5'd3,  5'd3,  1'b0, 5'd0, 32'h55,       32'h55,       2'b00, 6'd1));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3,  5'd3,  1'b0, 5'd0, 32'h55,       32'h55,       2'b00, 6'd0));
    vecs.push_back(mk(2'b10, 5'd0, 32'h0,        5'd9, 32'h99,   5'd9,  5'd9,  1'b1, 5'd9, 32'h99,       32'h99,       2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd9,  5'd9,  1'b0, 5'd0, 32'h99,       32'h99,       2'b11, 6'd1));
    vecs.push_back(mk(2'b01, 5'd9, 32'hAB,       5'd0, 32'h0,    5'd9,  5'd3,  1'b0, 5'd0, 32'hAB,       32'h55,       2'b00, 6'd1));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd9,  5'd0,  1'b0, 5'd0, 32'hAB,       32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd0,  1'b1, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd0,  1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd4,  5'd0,  1'b1, 5'd4, 32'h0,        32'h0,        2'b00, 6'd0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd4,  5'd4,  1'b1, 5'd4, 32'h0,        32'h0,        2'b11, 6'd1));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd4,  5'd4,  1'b0, 5'd0, 32'h0,        32'h0,        2'b11, 6'd1));

    repeat (2) @(negedge clk);
    #1;
    check("in_reset_busy_cnt", {26'd0, busy_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("rst_x%0d_port0", i), rdata[31:0], 32'h0);
      check($sformatf("rst_x%0d_port1", 31 - i), rdata[63:32], 32'h0);
      check($sformatf("rst_x%0d_rbusy", i), {30'd0, rbusy}, 32'd0);
    end
    check("rst_busy_cnt", {26'd0, busy_cnt}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i);
    end

    // x4 is already pending; add x1..x3 and store x10 before resetting mid-cycle.
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 5'd1;
    we = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h1234};
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 5'd2;
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 5'd3;
    @(negedge clk);
    idle();
    raddr = {5'd4, 5'd10};
    #1;
    check("pre_rst_busy_cnt", {26'd0, busy_cnt}, 32'd4);
    check("pre_rst_x10", rdata[31:0], 32'h1234);
    check("pre_rst_rbusy", {30'd0, rbusy}, 32'd2);

    we = 2'b01; waddr = {5'd0, 5'd11}; wdata = {32'h0, 32'h77};
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy_cnt", {26'd0, busy_cnt}, 32'd0);
    check("async_rst_x10", rdata[31:0], 32'h0);
    check("async_rst_rbusy", {30'd0, rbusy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    raddr = {5'd1, 5'd11};
    #1;
    check("dropped_write_x11", rdata[31:0], 32'h0);
    check("post_rst_rbusy", {30'd0, rbusy}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_busy_cnt", {26'd0, busy_cnt}, 32'd0);

    if (expq.size() != 0) check("scoreboard_drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
